// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: HI/LO registers, 32-cycle
// shift-add multiply and restoring divide, plus MTHI/MTLO/MFHI/MFLO access.
module ex_muldiv_unit #(
    parameter int SIZE          = 32,
    parameter int ALU_FUNC_SIZE = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [ALU_FUNC_SIZE-1:0] i_alu_func,
    input  logic [SIZE-1:0]          i_op_a,
    input  logic [SIZE-1:0]          i_op_b,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [SIZE-1:0]          o_result,
    output logic [SIZE-1:0]          o_hi,
    output logic [SIZE-1:0]          o_lo
);

    localparam logic [ALU_FUNC_SIZE-1:0] F_MULT  = ALU_FUNC_SIZE'(6'b011000);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MULTU = ALU_FUNC_SIZE'(6'b011001);
    localparam logic [ALU_FUNC_SIZE-1:0] F_DIV   = ALU_FUNC_SIZE'(6'b011010);
    localparam logic [ALU_FUNC_SIZE-1:0] F_DIVU  = ALU_FUNC_SIZE'(6'b011011);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MFHI  = ALU_FUNC_SIZE'(6'b010000);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MTHI  = ALU_FUNC_SIZE'(6'b010001);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MFLO  = ALU_FUNC_SIZE'(6'b010010);
    localparam logic [ALU_FUNC_SIZE-1:0] F_MTLO  = ALU_FUNC_SIZE'(6'b010011);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [5:0]        cnt;
    logic              is_div, neg_q, neg_r, div_zero;
    logic [SIZE-1:0]   a_hold, mag_m, hi_q, lo_q;
    logic [2*SIZE-1:0] work, work_nxt;

    logic              is_start, sgn_op, a_neg, b_neg, last;
    logic [SIZE-1:0]   mag_a, mag_b;
    logic [SIZE:0]     add_sum, trial;
    logic [2*SIZE:0]   shl;
    logic [2*SIZE-1:0] prod_fix;
    logic [SIZE-1:0]   q_fix, r_fix, res_hi, res_lo;

    assign is_start = i_valid && (state == S_IDLE) &&
                      (i_alu_func == F_MULT || i_alu_func == F_MULTU ||
                       i_alu_func == F_DIV  || i_alu_func == F_DIVU);
    assign sgn_op   = (i_alu_func == F_MULT) || (i_alu_func == F_DIV);
    assign a_neg    = sgn_op && i_op_a[SIZE-1];
    assign b_neg    = sgn_op && i_op_b[SIZE-1];
    assign mag_a    = a_neg ? -i_op_a : i_op_a;
    assign mag_b    = b_neg ? -i_op_b : i_op_b;
    assign last     = (cnt == 6'(SIZE-1));

    // work holds {partial_hi, multiplier} for multiply and {remainder, quotient}
    // for divide; mag_m is the multiplicand or the divisor respectively.
    always_comb begin
        add_sum = {1'b0, work[2*SIZE-1:SIZE]} + (work[0] ? {1'b0, mag_m} : '0);
        shl     = {work, 1'b0};
        trial   = shl[2*SIZE:SIZE] - {1'b0, mag_m};
        if (is_div) begin
            work_nxt = trial[SIZE] ? shl[2*SIZE-1:0]
                                   : {trial[SIZE-1:0], shl[SIZE-1:1], 1'b1};
        end else begin
            work_nxt = {add_sum, work[SIZE-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -work_nxt : work_nxt;
        q_fix    = neg_q ? -work_nxt[SIZE-1:0] : work_nxt[SIZE-1:0];
        r_fix    = neg_r ? -work_nxt[2*SIZE-1:SIZE] : work_nxt[2*SIZE-1:SIZE];
        res_hi   = prod_fix[2*SIZE-1:SIZE];
        res_lo   = prod_fix[SIZE-1:0];
        if (div_zero) begin
            res_hi = a_hold;
            res_lo = '1;
        end else if (is_div) begin
            res_hi = r_fix;
            res_lo = q_fix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (is_start) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            work     <= '0;
            mag_m    <= '0;
            a_hold   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_start) begin
                        cnt      <= '0;
                        is_div   <= (i_alu_func == F_DIV) || (i_alu_func == F_DIVU);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        a_hold   <= i_op_a;
                        div_zero <= ((i_alu_func == F_DIV) || (i_alu_func == F_DIVU)) &&
                                    (i_op_b == '0);
                        if ((i_alu_func == F_DIV) || (i_alu_func == F_DIVU)) begin
                            mag_m <= mag_b;
                            work  <= {{SIZE{1'b0}}, mag_a};
                        end else begin
                            mag_m <= mag_a;
                            work  <= {{SIZE{1'b0}}, mag_b};
                        end
                    end else if (i_valid && i_alu_func == F_MTHI) begin
                        hi_q <= i_op_a;
                    end else if (i_valid && i_alu_func == F_MTLO) begin
                        lo_q <= i_op_a;
                    end
                end
                S_RUN: begin
                    cnt  <= cnt + 6'd1;
                    work <= work_nxt;
                    if (last) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (state != S_IDLE);
    assign o_done   = (state == S_DONE);
    assign o_hi     = hi_q;
    assign o_lo     = lo_q;
    assign o_result = (i_alu_func == F_MFHI) ? hi_q :
                      (i_alu_func == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic reference model checked every cycle,
// with literal HI/LO pins for each completed operation.
module tb_ex_muldiv_unit;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] NOP   = 6'b100000;
    localparam int NPIN = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [5:0]  func = NOP;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result, hi, lo;

    ex_muldiv_unit #(.SIZE(32), .ALU_FUNC_SIZE(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_alu_func(func),
        .i_op_a(op_a), .i_op_b(op_b), .o_busy(busy), .o_done(done),
        .o_result(result), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: full-width arithmetic on the architectural operands.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        int unsigned     uq, ur;
        ref_op = '0;
        case (f)
            MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                ref_op = sp;
            end
            MULTU: begin
                up = longint'(a) * longint'(b);
                ref_op = up;
            end
            DIV: begin
                if (b == 32'h0) ref_op = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_op = {32'h0, 32'h80000000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    ref_op = {sr, sq};
                end
            end
            DIVU: begin
                if (b == 32'h0) ref_op = {a, 32'hFFFFFFFF};
                else begin
                    uq = a / b;
                    ur = a % b;
                    ref_op = {ur, uq};
                end
            end
            default: ref_op = '0;
        endcase
    endfunction

    logic        m_live = 1'b0;
    int          m_t = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (rst) begin
            m_t  <= 0;
            m_hi <= '0;
            m_lo <= '0;
        end else if (m_t == 0) begin
            if (valid && (func == MULT || func == MULTU || func == DIV || func == DIVU)) begin
                m_t    <= 1;
                m_pend <= ref_op(func, op_a, op_b);
            end else if (valid && func == MTHI) begin
                m_hi <= op_a;
            end else if (valid && func == MTLO) begin
                m_lo <= op_a;
            end
        end else if (m_t == 32) begin
            m_t <= 33;
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
        end else if (m_t == 33) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic [31:0] pin_hi [NPIN];
    logic [31:0] pin_lo [NPIN];
    int n_chk = 0;
    int n_fail = 0;
    int done_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", {31'b0, busy}, {31'b0, m_t != 0});
            chk("done", {31'b0, done}, {31'b0, m_t == 33});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("result", result, func == MFHI ? m_hi : func == MFLO ? m_lo : 32'h0);
            if (m_t == 33) begin
                if (done_idx < NPIN) begin
                    chk("pin_hi", hi, pin_hi[done_idx]);
                    chk("pin_lo", lo, pin_lo[done_idx]);
                end else begin
                    chk("extra_done", 32'(done_idx), 32'(NPIN - 1));
                end
                done_idx = done_idx + 1;
            end
        end
    end

    task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        valid = v;
        func  = f;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int idles);
        drive(1'b1, f, a, b);
        repeat (idles) drive(1'b0, NOP, '0, '0);
    endtask

    initial begin
        pin_hi[0] = 32'hFFFFFFFF; pin_lo[0] = 32'hFFFFFFFA;
        pin_hi[1] = 32'hFFFFFFFE; pin_lo[1] = 32'h00000001;
        pin_hi[2] = 32'hFFFFFFFF; pin_lo[2] = 32'hFFFFFFFD;
        pin_hi[3] = 32'h00000007; pin_lo[3] = 32'hFFFFFFFF;
        pin_hi[4] = 32'h00000000; pin_lo[4] = 32'h80000000;
        pin_hi[5] = 32'hFFFFFF9C; pin_lo[5] = 32'hFFFFFFFF;
        pin_hi[6] = 32'h00000000; pin_lo[6] = 32'h0000000F;
        pin_hi[7] = 32'h00000002; pin_lo[7] = 32'h0000000E;
        pin_hi[8] = 32'h00000000; pin_lo[8] = 32'h0000000F;
        pin_hi[9] = 32'h00000001; pin_lo[9] = 32'hFFFFFFFD;

        repeat (2) drive(1'b0, NOP, '0, '0);
        rst = 1'b0;
        drive(1'b0, MFHI, '0, '0);

        run_op(MULT,  32'hFFFFFFFE, 32'h00000003, 34);
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op(DIV,   32'hFFFFFFF9, 32'h00000002, 34);
        run_op(DIVU,  32'h00000007, 32'h00000000, 33);
        run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 34);
        run_op(DIV,   32'hFFFFFF9C, 32'h00000000, 34);

        drive(1'b1, MTHI, 32'h12345678, '0);
        drive(1'b0, MFHI, '0, '0);
        drive(1'b1, MTLO, 32'hCAFEF00D, '0);
        drive(1'b0, MFLO, '0, '0);

        drive(1'b1, MULTU, 32'h3, 32'h5);
        drive(1'b1, MTLO, 32'hAAAAAAAA, '0);
        drive(1'b1, MULT, 32'h7, 32'h7);
        drive(1'b1, MTHI, 32'h55555555, '0);
        repeat (31) drive(1'b0, MFLO, '0, '0);

        drive(1'b1, DIVU, 32'd100, 32'd7);
        repeat (10) drive(1'b0, NOP, '0, '0);
        rst = 1'b1;
        drive(1'b0, NOP, '0, '0);
        rst = 1'b0;
        run_op(DIVU, 32'd100, 32'd7, 34);

        run_op(MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 34);
        run_op(DIV,  32'h00000007, 32'hFFFFFFFE, 34);

        rst = 1'b1;
        drive(1'b1, MTHI, 32'h1, '0);
        rst = 1'b0;
        repeat (2) drive(1'b0, MFHI, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter SIZE, default 32, operand/result width.
REQ-002 SHALL have parameter ALU_FUNC_SIZE, default 6, width of function code from ALU control.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  EX-stage instruction present this cycle.
REQ-006 SHALL have port i_alu_func  input  ALU_FUNC_SIZE  function code as produced by ALU control.
REQ-007 SHALL have port i_op_a  input  SIZE  rs operand (multiplicand / dividend / MTHI-MTLO source).
REQ-008 SHALL have port i_op_b  input  SIZE  rt operand (multiplier / divisor).
REQ-009 SHALL have port o_busy  output  1  unit occupied; pipeline stalls while high.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse, HI/LO hold the new result.
REQ-011 SHALL have port o_result  output  SIZE  HI for MFHI, LO for MFLO, else 0.
REQ-012 SHALL have ports o_hi, o_lo  output  SIZE each  current HI and LO register contents.

Function
REQ-013 SHALL decode MULT=011000, MULTU=011001, DIV=011010, DIVU=011011, MFHI=010000, MTHI=010001, MFLO=010010, MTLO=010011; all other codes ignored.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; o_busy = (state != IDLE); o_done = (state == DONE).
REQ-015 SHALL accept a start only in IDLE with i_valid=1 and func in {MULT,MULTU,DIV,DIVU}: latch operands, signedness, op type; go to RUN, 6-bit counter = 0.
REQ-016 SHALL perform one iteration per RUN cycle: shift-add multiply, or restoring divide, on operand magnitudes; exactly 32 RUN cycles (counter 0..31).
REQ-017 SHALL, at the edge ending counter=31, write HI/LO and go to DONE; DONE lasts one cycle, then IDLE.
REQ-018 SHALL give latency: start edge E0 -> o_done high in the cycle after E32; HI/LO new values visible from that cycle; next start accepted at E34 earliest.
REQ-019 SHALL, for signed ops, use |a|,|b|; negate 64-bit product if signs differ; quotient negated if signs differ, remainder takes sign of dividend.
REQ-020 SHALL, for MULT/MULTU, set HI = product[63:32], LO = product[31:0].
REQ-021 SHALL, for DIV/DIVU, set LO = quotient, HI = remainder.
REQ-022 SHALL, on divisor 0 (either signedness), set HI = i_op_a as latched, LO = 0xFFFFFFFF, with unchanged latency.
REQ-023 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, set LO = 0x80000000, HI = 0.
REQ-024 SHALL, in IDLE with i_valid=1, write HI (MTHI) or LO (MTLO) from i_op_a at the same edge; no busy.
REQ-025 SHALL ignore i_valid (any func, including MTHI/MTLO and new starts) while o_busy=1; HI/LO unchanged until DONE.
REQ-026 SHALL drive o_result combinationally from i_alu_func and current HI/LO; consumers treat it valid only when o_busy=0.

Reset
REQ-027 SHALL, when i_rst=1 at an edge, set state IDLE, counter 0, HI=LO=0, o_busy=0, o_done=0, regardless of operation in flight (abort, no partial write).
REQ-028 SHALL give i_rst priority over every start, MTHI/MTLO and iteration at the same edge.

Verification
REQ-029 SHALL verify MULT a=0xFFFFFFFE, b=0x00000003 -> o_done after 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 SHALL verify MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 SHALL verify DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
REQ-032 SHALL verify MTHI 0x12345678 then MFHI -> o_result=0x12345678 next cycle, o_busy never high.
REQ-033 SHALL verify MULTU 3*5 started, then i_valid MTLO 0xAAAAAAAA and second MULT during busy -> ignored; LO=0x0000000F, HI=0 at o_done; single o_done pulse.
REQ-034 SHALL verify i_rst at RUN counter=10 of DIVU 100/7 -> next cycle o_busy=0, o_done=0, HI=LO=0; new start accepted immediately after.
